// File: rtl/plic_claim_ctrl_pkg.sv
// plic_claim_ctrl_pkg
//   Shared PLIC constants: source count, id/priority widths, edge-gateway
//   pending-counter width and the trigger-mode encoding.
package plic_claim_ctrl_pkg;

  localparam int unsigned IRQ_NUM  = 32;  // sources, including reserved id 0
  localparam int unsigned IRQ_WID  = 5;   // log2(IRQ_NUM)
  localparam int unsigned PRIO_WID = 4;   // per-source priority 0..15
  localparam int unsigned GWP_WID  = 3;   // edge-gateway pending-edge counter

  typedef enum logic {
    TM_LEVL = 1'b0,
    TM_EDGE = 1'b1
  } tm_e;

endpackage

// File: rtl/plic_claim_ctrl_if.sv
// plic_claim_ctrl_if
//   CLAIMCOMP handshake between the PLIC register file (master) and the
//   interrupt-target core (slave).
//     claim_i       : one-cycle CLAIMCOMP read strobe
//     claim_id_o    : id returned by the last claim
//     complete_i    : one-cycle CLAIMCOMP write strobe
//     complete_id_i : id being completed
interface plic_claim_ctrl_if
  import plic_claim_ctrl_pkg::*;
();

  logic               claim_i;
  logic [IRQ_WID-1:0] claim_id_o;
  logic               complete_i;
  logic [IRQ_WID-1:0] complete_id_i;

  modport master (
    output claim_i,
    output complete_i,
    output complete_id_i,
    input  claim_id_o
  );

  modport slave (
    input  claim_i,
    input  complete_i,
    input  complete_id_i,
    output claim_id_o
  );

endinterface

// File: rtl/plic_claim_ctrl_gateway.sv
// plic_gateway
//   Per-source interrupt gateway. Turns the raw line into a pending bit,
//   in level mode (re-pends while the line is high and the source is idle)
//   or edge mode (rising edges that arrive while pending/in service are
//   queued in a saturating counter and drained one at a time).
//     clk_i, rst_i : clock, async active-high reset
//     tm           : trigger mode (TM_LEVL / TM_EDGE)
//     irq          : raw interrupt line
//     is           : source is in service
//     claim_clr    : source is being claimed this cycle
//     ip           : pending bit
module plic_gateway
  import plic_claim_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic tm,
  input  logic irq,
  input  logic is,
  input  logic claim_clr,
  output logic ip
);

  logic               irq_q, irq_d;
  logic               ip_q, ip_d;
  logic [GWP_WID-1:0] cnt_q, cnt_d;
  logic               free;

  always_comb begin
    irq_d = irq;
    ip_d  = ip_q;
    cnt_d = cnt_q;
    free  = ~ip_q & ~is;
    if (tm == TM_LEVL) begin
      cnt_d = '0;
      if (irq && free) ip_d = 1'b1;
    end else if (irq && !irq_q) begin
      // A new edge wins over draining the counter in the same cycle.
      if (free)              ip_d  = 1'b1;
      else if (cnt_q != '1)  cnt_d = cnt_q + 1'b1;
    end else if (cnt_q != '0 && free) begin
      ip_d  = 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
    if (claim_clr) ip_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
      ip_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      irq_q <= irq_d;
      ip_q  <= ip_d;
      cnt_q <= cnt_d;
    end
  end

  assign ip = ip_q;

endmodule

// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl
//   PLIC interrupt-target core: per-source gateways, in-service tracking,
//   registered priority resolver and the claim/complete handshake that
//   drives the hart external interrupt line.
//     clk_i, rst_i : clock, async active-high reset
//     en_i         : CTRL.EN global enable (gateways run regardless)
//     tm_i         : per-source trigger mode, 0 level / 1 edge
//     prio_i       : priorities, source k at [k*PRIO_WID +: PRIO_WID]
//     ie_i         : per-source enable
//     thold_i      : priority threshold (strictly greater is eligible)
//     irq_i        : raw lines, bit 0 ignored
//     bus          : CLAIMCOMP handshake (slave side)
//     ip_o         : pending bits for the IP register
//     ext_irq_o    : external interrupt request to the hart
module plic_claim_ctrl
  import plic_claim_ctrl_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [IRQ_NUM-1:0]           tm_i,
  input  logic [IRQ_NUM*PRIO_WID-1:0]  prio_i,
  input  logic [IRQ_NUM-1:0]           ie_i,
  input  logic [PRIO_WID-1:0]          thold_i,
  input  logic [IRQ_NUM-1:0]           irq_i,
  plic_claim_ctrl_if.slave             bus,
  output logic [IRQ_NUM-1:0]           ip_o,
  output logic                         ext_irq_o
);

  logic [IRQ_NUM-1:0]  ip;
  logic [IRQ_NUM-1:0]  is_q, is_d;
  logic [IRQ_NUM-1:0]  claim_clr;
  logic [IRQ_WID-1:0]  best_id_q, best_id_d;
  logic [IRQ_WID-1:0]  claim_id_q, claim_id_d;
  logic [IRQ_WID-1:0]  res_id;
  logic [PRIO_WID-1:0] res_prio;
  logic                claim_hit;
  logic                unused_bits;

  // Source 0 has no gateway; its line and mode bits are don't-care.
  assign unused_bits = ^{tm_i[0], irq_i[0]};
  assign ip[0]       = 1'b0;

  for (genvar k = 1; k < IRQ_NUM; k++) begin : g_gw
    plic_gateway u_gw (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tm        (tm_i[k]),
      .irq       (irq_i[k]),
      .is        (is_q[k]),
      .claim_clr (claim_clr[k]),
      .ip        (ip[k])
    );
  end

  // Highest priority wins; strict compare keeps the lowest id on ties.
  // res_prio starts at 0 and eligibility needs prio > thold, so a
  // priority-0 source can never be selected.
  always_comb begin
    res_id   = '0;
    res_prio = '0;
    for (int unsigned k = 1; k < IRQ_NUM; k++) begin
      if (ip[k] && ie_i[k] &&
          prio_i[k*PRIO_WID +: PRIO_WID] > thold_i &&
          prio_i[k*PRIO_WID +: PRIO_WID] > res_prio) begin
        res_id   = IRQ_WID'(k);
        res_prio = prio_i[k*PRIO_WID +: PRIO_WID];
      end
    end
  end

  // The post-claim blank is folded into best_id_q: the claiming edge loads
  // 0, so ext_irq_o drops for one cycle and a back-to-back claim returns 0;
  // the following edge re-resolves from the already-cleared ip.
  always_comb begin
    claim_hit  = bus.claim_i & en_i & (best_id_q != '0);
    claim_id_d = claim_id_q;
    if (bus.claim_i) claim_id_d = en_i ? best_id_q : '0;
    claim_clr  = claim_hit ? (IRQ_NUM'(1) << best_id_q) : '0;
    best_id_d  = claim_hit ? '0 : res_id;
    is_d       = is_q;
    if (bus.complete_i) is_d[bus.complete_id_i] = 1'b0;
    if (claim_hit)      is_d[best_id_q]         = 1'b1;
    is_d[0]    = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_q       <= '0;
      best_id_q  <= '0;
      claim_id_q <= '0;
    end else begin
      is_q       <= is_d;
      best_id_q  <= best_id_d;
      claim_id_q <= claim_id_d;
    end
  end

  assign bus.claim_id_o = claim_id_q;
  assign ip_o           = ip;
  assign ext_irq_o      = en_i & (best_id_q != '0);

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// tb_plic_claim_ctrl
//   Directed scenarios followed by a randomized phase, all cross-checked
//   against a cycle-level behavioural model of the interrupt target.
module tb_plic_claim_ctrl;
  import plic_claim_ctrl_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        en;
  logic [IRQ_NUM-1:0]          tm;
  logic [IRQ_NUM*PRIO_WID-1:0] prio;
  logic [IRQ_NUM-1:0]          ie;
  logic [PRIO_WID-1:0]         thold;
  logic [IRQ_NUM-1:0]          irq;
  logic [IRQ_NUM-1:0]          ip_o;
  logic                        ext_irq_o;

  int total = 0;
  int bad   = 0;

  plic_claim_ctrl_if bus ();

  plic_claim_ctrl dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .tm_i      (tm),
    .prio_i    (prio),
    .ie_i      (ie),
    .thold_i   (thold),
    .irq_i     (irq),
    .bus       (bus),
    .ip_o      (ip_o),
    .ext_irq_o (ext_irq_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_ip   [IRQ_NUM];
  bit m_is   [IRQ_NUM];
  bit m_prev [IRQ_NUM];
  int m_cnt  [IRQ_NUM];
  int m_best;
  int m_cid;
  int m_hit;
  int m_next;
  bit m_set;

  function automatic int prio_of(input int k);
    return int'(prio[k*PRIO_WID +: PRIO_WID]);
  endfunction

  // Best = maximum priority over eligible sources, then the first id at it.
  function automatic int resolve();
    int top = 0;
    for (int k = 1; k < IRQ_NUM; k++)
      if (m_ip[k] && ie[k] && prio_of(k) > int'(thold) && prio_of(k) > top)
        top = prio_of(k);
    if (top == 0) return 0;
    for (int k = 1; k < IRQ_NUM; k++)
      if (m_ip[k] && ie[k] && prio_of(k) == top) return k;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < IRQ_NUM; k++) begin
        m_ip[k] = 0; m_is[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
      end
      m_best = 0;
      m_cid  = 0;
    end else begin
      m_hit = (bus.claim_i && en && m_best != 0) ? m_best : 0;
      if (bus.claim_i) m_cid = en ? m_best : 0;
      m_next = (m_hit != 0) ? 0 : resolve();
      for (int k = 1; k < IRQ_NUM; k++) begin
        m_set = 0;
        if (!tm[k]) begin
          m_cnt[k] = 0;
          m_set = irq[k] && !m_ip[k] && !m_is[k];
        end else if (irq[k] && !m_prev[k]) begin
          if (!m_ip[k] && !m_is[k]) m_set = 1;
          else if (m_cnt[k] < 7)    m_cnt[k]++;
        end else if (m_cnt[k] > 0 && !m_ip[k] && !m_is[k]) begin
          m_set = 1;
          m_cnt[k]--;
        end
        m_prev[k] = irq[k];
        if (m_set) m_ip[k] = 1;
        if (k == m_hit) m_ip[k] = 0;
      end
      if (bus.complete_i && bus.complete_id_i != 0) m_is[bus.complete_id_i] = 0;
      if (m_hit != 0) m_is[m_hit] = 1;
      m_best = m_next;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mcheck();
    logic [31:0] v;
    for (int k = 0; k < IRQ_NUM; k++) v[k] = m_ip[k];
    chk("model_ip", ip_o, v);
    chk("model_ext", 32'(ext_irq_o), 32'(en && m_best != 0));
    chk("model_claim_id", 32'(bus.claim_id_o), m_cid);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    mcheck();
  endtask

  task automatic do_claim(input string tag, input int exp);
    bus.claim_i = 1'b1;
    cyc();
    bus.claim_i = 1'b0;
    chk(tag, 32'(bus.claim_id_o), exp);
  endtask

  task automatic do_complete(input int id);
    bus.complete_i    = 1'b1;
    bus.complete_id_i = IRQ_WID'(id);
    cyc();
    bus.complete_i    = 1'b0;
  endtask

  task automatic pulse(input int k);
    irq[k] = 1'b1;
    cyc();
    irq[k] = 1'b0;
    cyc();
  endtask

  task automatic set_prio(input int k, input int p);
    prio[k*PRIO_WID +: PRIO_WID] = PRIO_WID'(p);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b1; tm = '0; prio = '0; ie = '0; thold = '0; irq = '0;
    bus.claim_i = 1'b0; bus.complete_i = 1'b0; bus.complete_id_i = '0;
    #12;
    chk("rst_ip", ip_o, 32'h0);
    chk("rst_ext", 32'(ext_irq_o), 32'h0);
    chk("rst_claim_id", 32'(bus.claim_id_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Level basic
    set_prio(3, 5); ie[3] = 1'b1; thold = 4'd2; irq[3] = 1'b1;
    cyc();
    chk("lvl_ip_plus1", 32'(ip_o[3]), 32'h1);
    chk("lvl_ext_plus1", 32'(ext_irq_o), 32'h0);
    cyc();
    chk("lvl_ext_plus2", 32'(ext_irq_o), 32'h1);
    do_claim("lvl_claim", 3);
    chk("lvl_ip_cleared", 32'(ip_o[3]), 32'h0);
    chk("lvl_ext_blank", 32'(ext_irq_o), 32'h0);
    cyc();
    chk("lvl_no_repend_in_service", 32'(ip_o[3]), 32'h0);
    do_complete(3);
    chk("lvl_after_complete", 32'(ip_o[3]), 32'h0);
    cyc();
    chk("lvl_repend", 32'(ip_o[3]), 32'h1);
    irq[3] = 1'b0;
    cyc();
    do_claim("lvl_claim2", 3);
    do_complete(3);
    ie[3] = 1'b0; set_prio(3, 0);

    // Arbitration
    set_prio(4, 7); set_prio(9, 7); set_prio(12, 3);
    ie[4] = 1'b1; ie[9] = 1'b1; ie[12] = 1'b1;
    irq[4] = 1'b1; irq[9] = 1'b1; irq[12] = 1'b1;
    cyc();
    irq = '0;
    cyc();
    do_claim("arb_first", 4);
    do_claim("arb_back_to_back", 0);
    do_claim("arb_second", 9);
    cyc();
    do_claim("arb_third", 12);
    do_complete(4); do_complete(9); do_complete(12);
    ie = '0; prio = '0;

    // Threshold / enable
    set_prio(6, 2); ie[6] = 1'b1; thold = 4'd2; irq[6] = 1'b1;
    cyc();
    irq[6] = 1'b0;
    cyc(); cyc();
    chk("thr_equal_blocks", 32'(ext_irq_o), 32'h0);
    thold = 4'd1;
    cyc();
    chk("thr_lowered", 32'(ext_irq_o), 32'h1);
    ie[6] = 1'b0;
    cyc();
    chk("thr_ie_cleared", 32'(ext_irq_o), 32'h0);
    ie[6] = 1'b1;
    cyc();
    do_claim("thr_claim", 6);
    do_complete(6);
    ie[6] = 1'b0; set_prio(6, 0);

    // Edge counting with saturation
    tm[8] = 1'b1; set_prio(8, 4); ie[8] = 1'b1;
    pulse(8);
    do_claim("edge_first", 8);
    for (int i = 0; i < 10; i++) pulse(8);
    chk("edge_in_service_no_ip", 32'(ip_o[8]), 32'h0);
    for (int i = 0; i < 7; i++) begin
      do_complete(8);
      cyc(); cyc();
      do_claim("edge_drain", 8);
    end
    do_complete(8);
    cyc(); cyc(); cyc();
    chk("edge_drained_ip", 32'(ip_o[8]), 32'h0);
    chk("edge_drained_ext", 32'(ext_irq_o), 32'h0);
    do_claim("edge_empty", 0);
    tm[8] = 1'b0; ie[8] = 1'b0; set_prio(8, 0);

    // Global disable
    en = 1'b0; set_prio(2, 3); ie[2] = 1'b1;
    pulse(2);
    cyc();
    chk("dis_ext", 32'(ext_irq_o), 32'h0);
    do_claim("dis_claim", 0);
    chk("dis_ip_kept", 32'(ip_o[2]), 32'h1);
    en = 1'b1;
    cyc();
    chk("dis_reenable", 32'(ext_irq_o), 32'h1);
    do_claim("dis_claim_after", 2);
    do_complete(2);
    ie[2] = 1'b0; set_prio(2, 0);

    // Asynchronous reset mid-service
    tm[5] = 1'b1; set_prio(5, 5); ie[5] = 1'b1;
    pulse(5);
    do_claim("rst_pre_claim", 5);
    for (int i = 0; i < 3; i++) pulse(5);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_ip", ip_o, 32'h0);
    chk("rst_async_ext", 32'(ext_irq_o), 32'h0);
    chk("rst_async_claim_id", 32'(bus.claim_id_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_complete(5);
    cyc(); cyc(); cyc();
    chk("rst_cnt_cleared", 32'(ip_o[5]), 32'h0);
    tm = '0; ie = '0; prio = '0;

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) en = ($urandom_range(5) != 0);
      if ($urandom_range(19) == 0) tm = $urandom;
      if ($urandom_range(9) == 0) begin
        for (int k = 0; k < IRQ_NUM; k++) set_prio(k, int'($urandom_range(15)));
      end
      if ($urandom_range(9) == 0) ie = $urandom | $urandom;
      if ($urandom_range(14) == 0) thold = PRIO_WID'($urandom_range(4));
      irq = $urandom & $urandom;
      bus.claim_i = ($urandom_range(2) == 0);
      bus.complete_i = ($urandom_range(2) == 0);
      bus.complete_id_i = IRQ_WID'($urandom_range(IRQ_NUM - 1));
      for (int j = 0; j < IRQ_NUM; j++) begin
        int c = (int'(bus.complete_id_i) + j) % IRQ_NUM;
        if (m_is[c]) begin
          bus.complete_id_i = IRQ_WID'(c);
          break;
        end
      end
      cyc();
    end
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plic_claim_ctrl.md
# plic_claim_ctrl

Interrupt-target core of the PLIC: per-source gateways, pending/in-service tracking, a registered priority resolver and the claim/complete handshake that drives the hart's external interrupt line. Sits between the PLIC register file (which supplies CTRL.EN, TM, PRIO, IE and THOLD, and strobes CLAIMCOMP reads/writes) and the raw `irq_i` inputs. Register decoding stays in the register file; this block owns all interrupt state.

## Interface
- `IRQ_NUM`, 32: number of sources including reserved id 0.
- `IRQ_WID`, 5: id width, log2(IRQ_NUM).
- `PRIO_WID`, 4: per-source priority width (0..15).
- `GWP_WID`, 3: edge-gateway pending-edge counter width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `en_i` in 1: CTRL.EN global enable.
- `tm_i` in IRQ_NUM: trigger mode per source, 0 = level, 1 = edge.
- `prio_i` in IRQ_NUM*PRIO_WID: priorities; source k at [k*PRIO_WID +: PRIO_WID].
- `ie_i` in IRQ_NUM: enable per source.
- `thold_i` in PRIO_WID: threshold.
- `irq_i` in IRQ_NUM: raw interrupt inputs; bit 0 ignored.
- `claim_i` in 1: one-cycle CLAIMCOMP read strobe.
- `claim_id_o` out IRQ_WID: id returned by the last claim.
- `complete_i` in 1: one-cycle CLAIMCOMP write strobe.
- `complete_id_i` in IRQ_WID: id being completed.
- `ip_o` out IRQ_NUM: pending bits, for the IP register.
- `ext_irq_o` out 1: external interrupt request to the hart.

## Operation
- Reset clears `ip`, `is` (in-service), the edge counters, the `irq_i` history, `best_id_q`, `best_prio_q`, `claim_id_o` and the post-claim blank flag. All outputs are 0.
- Id 0 is never pending, never in service and never selected.
- **Level gateway:** sets `ip[k]` when `irq_i[k]`=1, `ip[k]`=0 and `is[k]`=0. It does not clear `ip` when `irq_i` falls.
- **Edge gateway:**
  - A rising edge is `irq_i[k]` & ~`irq_q[k]`.
  - On a rising edge: if `ip[k]`=0 and `is[k]`=0, set `ip[k]` directly. Otherwise increment `cnt[k]`, saturating at 2^GWP_WID-1.
  - With no edge: if `cnt[k]`>0, `ip[k]`=0 and `is[k]`=0, set `ip[k]` and decrement `cnt[k]`.
  - `cnt[k]` is forced to 0 while `tm_i[k]`=0.
- **Eligibility:** source k is eligible when `ip[k]`, `ie_i[k]` and `prio[k]` > `thold_i` all hold. Priority 0 is therefore never eligible.
- **Resolver:** combinationally picks the highest priority among eligible sources; ties go to the lowest id. The result registers into `best_id_q`/`best_prio_q` (0 if none).
- `ext_irq_o` = `en_i` & (`best_id_q` != 0).
- **Claim** (`claim_i`=1):
  - `claim_id_o` <= (`en_i` ? `best_id_q` : 0).
  - If that id is non-zero: clear its `ip`, set its `is`, and set the blank flag.
  - While the blank flag is set (exactly the next cycle), `best_id_q` loads 0.
- **Complete** (`complete_i`=1): clears `is[complete_id_i]` if it is set. Otherwise ignored; id 0 is a no-op.
- `en_i`=0 does not stop the gateways; pending bits still accumulate.

## Timing
- Level source: `irq_i` high at edge t gives `ip_o` at t+1, `best_id_q` at t+2, `ext_irq_o` at t+2.
- Edge source: same latency when the direct path applies.
- Claim at edge t: `claim_id_o` valid and `ip` cleared after t. `ext_irq_o`=0 for cycle t+1; it re-asserts at t+2 if another source is eligible.
- A claim at t+1 (back-to-back) returns 0.
- Complete at t: `is` clears after t. A source whose level is still high re-pends at t+1; an edge source with `cnt`>0 re-pends at t+1.
- Simultaneous claim of X and complete of Y: both apply.
- Simultaneous rising edge and counter drain on the same source: the edge path has priority and the counter is unchanged.
- Priority, threshold or IE changes take effect on `best_id_q` one cycle later.
- Reset asserted mid-operation returns every bit to its reset value immediately (asynchronous).

## Structure
- Shared PLIC define header: IRQ_NUM, IRQ_WID, PRIO_WID, GWP_WID, and the TM_LEVL/TM_EDGE encodings.
- Sub-module `plic_gateway`, one per source (generate for k=1..IRQ_NUM-1). Inputs: `tm`, `irq`, `is`, `claim_clr`. Owns `irq_q`, `cnt` and `ip`.
- Resolver stays in `plic_claim_ctrl` as a loop-based compare feeding the pipeline register.

## Test plan
- Level basic: `en`=1, IRQ3 prio 5, `ie`[3]=1, thold 2, `irq_i`[3]=1. Expect `ip_o`[3] at +1 and `ext_irq_o` at +2. Claim returns 3. Complete id 3 with the line still high: `ip_o`[3] set again one cycle later.
- Arbitration: IRQ4 and IRQ9 at prio 7, IRQ12 at prio 3. Claims return 4, then 9 (after the blank cycle), then 12. A back-to-back claim returns 0.
- Threshold/enable: IRQ6 prio 2 with thold 2 gives `ext_irq_o`=0. Set thold 1: `ext_irq_o`=1 one cycle later. Clear `ie`[6]: `ext_irq_o`=0 one cycle later.
- Edge counting: `tm`[8]=1, 10 pulses on IRQ8 while it is in service. `cnt` saturates at 7, so exactly 7 further claims return 8, each after its complete.
- Disable: `en`=0 with IRQ2 pending. `ext_irq_o`=0, claim returns 0, `ip_o`[2] stays 1. Setting `en`=1 gives `ext_irq_o`=1.
- Reset mid-service: IRQ5 in service with `cnt` 3, assert `rst_i` asynchronously. All outputs read 0 and the counters are cleared.
